count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl_pkg.sv | 16 +
 rtl/count_core.sv | 24 ++
 rtl/count_ctrl.sv | 113 +++++++++++
 tb/tb_count_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl block: FSM state encoding,
// run-mode encodings and the reload-counter saturation limit.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic       MODE_ONESHOT = 1'b0;
    localparam logic       MODE_RELOAD  = 1'b1;
    localparam logic [3:0] RELOAD_MAX   = 4'd15;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up-counter with synchronous clear and enable and an asynchronous
// active-low reset; the parent FSM decides when to clear or advance it.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Run controller: captures a terminal count and mode on start, drives a
// count_core through LOAD/RUN, and reports busy, done pulses and reload wraps.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] tc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       reloads
);

    state_t           state;
    logic [WIDTH-1:0] tc_q;
    logic             mode_q;
    logic             core_clr;
    logic             core_en;
    logic             at_tc;

    assign at_tc = (count == tc_q);

    // Counter control is decoded from registered state only, so count itself
    // stays a pure register output.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        core_clr = 1'b0;
        core_en  = 1'b0;
        case (state)
            LOAD: core_clr = 1'b1;
            RUN: begin
                if (stop) begin
                    core_clr = 1'b1;
                end else if (at_tc) begin
                    core_clr = (mode_q == MODE_RELOAD);
                end else begin
                    core_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    count_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (core_clr),
        .en    (core_en),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tc_q    <= '0;
            mode_q  <= MODE_ONESHOT;
            reloads <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !stop) begin
                        tc_q   <= tc;
                        mode_q <= mode;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    reloads <= '0;
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // stop outranks reaching the terminal count
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (at_tc) begin
                        done <= 1'b1;
                        if (mode_q == MODE_RELOAD) begin
                            if (reloads != RELOAD_MAX) begin
                                reloads <= reloads + 4'd1;
                            end
                        end else begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Directed self-checking bench for count_ctrl; cycle n is the interval after
// the n-th rising edge following the edge that samples start.
module tb_count_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] tc = 4'd0;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic [3:0] reloads;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    count_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .tc      (tc),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .reloads (reloads)
    );

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic launch(input logic [3:0] t, input logic m);
        start = 1'b1;
        tc    = t;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        #3;
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done got=%0d exp=0", done); end
        tests++; if (count !== 4'd0)   begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (reloads !== 4'd0) begin fails++; $display("FAIL reset_reloads got=%0d exp=0", reloads); end
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_oneshot;
        logic       exp_busy;
        logic       exp_done;
        logic [3:0] exp_count;
        launch(4'd5, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            exp_busy  = (n >= 1 && n <= 7);
            exp_done  = (n == 8);
            exp_count = (n >= 7) ? 4'd5 : 4'(n - 2);
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL oneshot_busy c%0d got=%0d exp=%0d", n, busy, exp_busy); end
            tests++; if (done !== exp_done) begin fails++; $display("FAIL oneshot_done c%0d got=%0d exp=%0d", n, done, exp_done); end
            if (n >= 2) begin
                tests++; if (count !== exp_count) begin fails++; $display("FAIL oneshot_count c%0d got=%0d exp=%0d", n, count, exp_count); end
            end
            @(negedge clk);
        end
        idle_cycles(1);
    endtask

    task automatic test_reload;
        logic       exp_done;
        logic [3:0] exp_count;
        logic [3:0] exp_rel;
        launch(4'd3, 1'b1);
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            exp_count = 4'((n - 2) % 4);
            exp_done  = (n >= 6) && ((n - 2) % 4 == 0);
            exp_rel   = 4'((n - 2) / 4);
            tests++; if (busy !== 1'b1)       begin fails++; $display("FAIL reload_busy c%0d got=%0d exp=1", n, busy); end
            tests++; if (count !== exp_count) begin fails++; $display("FAIL reload_count c%0d got=%0d exp=%0d", n, count, exp_count); end
            tests++; if (done !== exp_done)   begin fails++; $display("FAIL reload_done c%0d got=%0d exp=%0d", n, done, exp_done); end
            tests++; if (reloads !== exp_rel) begin fails++; $display("FAIL reload_reloads c%0d got=%0d exp=%0d", n, reloads, exp_rel); end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reload_stop_busy got=%0d exp=0", busy); end
        tests++; if (count !== 4'd0)   begin fails++; $display("FAIL reload_stop_count got=%0d exp=0", count); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reload_stop_done got=%0d exp=0", done); end
        idle_cycles(2);
        tests++; if (reloads !== 4'd4) begin fails++; $display("FAIL idle_hold_reloads got=%0d exp=4", reloads); end
        tests++; if (count !== 4'd0)   begin fails++; $display("FAIL idle_hold_count got=%0d exp=0", count); end
    endtask

    task automatic test_reload_tc0;
        logic       exp_done;
        logic [3:0] exp_rel;
        launch(4'd0, 1'b1);
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            exp_done = (n >= 3);
            exp_rel  = (n - 2 > 15) ? 4'd15 : 4'(n - 2);
            tests++; if (done !== exp_done)   begin fails++; $display("FAIL tc0_done c%0d got=%0d exp=%0d", n, done, exp_done); end
            tests++; if (reloads !== exp_rel) begin fails++; $display("FAIL tc0_reloads c%0d got=%0d exp=%0d", n, reloads, exp_rel); end
            tests++; if (count !== 4'd0)      begin fails++; $display("FAIL tc0_count c%0d got=%0d exp=0", n, count); end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tc0_stop_busy got=%0d exp=0", busy); end
        idle_cycles(1);
    endtask

    task automatic test_stop_at_tc;
        launch(4'd4, 1'b0);
        idle_cycles(5);
        tests++; if (count !== 4'd4) begin fails++; $display("FAIL stoptc_pre_count got=%0d exp=4", count); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL stoptc_done c7 got=%0d exp=0", done); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL stoptc_busy c7 got=%0d exp=0", busy); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL stoptc_count c7 got=%0d exp=0", count); end
        @(negedge clk);
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL stoptc_done c8 got=%0d exp=0", done); end
        idle_cycles(1);
    endtask

    task automatic test_start_stop_and_ignore;
        start = 1'b1;
        stop  = 1'b1;
        tc    = 4'd2;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL startstop_busy c%0d got=%0d exp=0", n, busy); end
            @(negedge clk);
        end
        // run tc=3 one-shot; a second start with tc=9 mid-run must be ignored
        launch(4'd3, 1'b0);
        idle_cycles(2);
        start = 1'b1;
        tc    = 4'd9;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if (count !== 4'd2) begin fails++; $display("FAIL ignore_count c4 got=%0d exp=2", count); end
        idle_cycles(1);
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL ignore_count c5 got=%0d exp=3", count); end
        @(negedge clk);
        tests++; if (done !== 1'b1)  begin fails++; $display("FAIL ignore_done c6 got=%0d exp=1", done); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL ignore_busy c6 got=%0d exp=0", busy); end
        @(negedge clk);
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL ignore_hold c7 got=%0d exp=3", count); end
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL ignore_done c7 got=%0d exp=0", done); end
        mode = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_run;
        logic exp_busy;
        logic exp_done;
        launch(4'd7, 1'b0);
        idle_cycles(3);
        #2;
        reset = 1'b0;
        #1;
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL midreset_count got=%0d exp=0", count); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL midreset_busy got=%0d exp=0", busy); end
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL midreset_done got=%0d exp=0", done); end
        @(negedge clk);
        reset = 1'b1;
        launch(4'd2, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            exp_busy = (n <= 4);
            exp_done = (n == 5);
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL postreset_busy c%0d got=%0d exp=%0d", n, busy, exp_busy); end
            tests++; if (done !== exp_done) begin fails++; $display("FAIL postreset_done c%0d got=%0d exp=%0d", n, done, exp_done); end
            @(negedge clk);
        end
        tests++; if (count !== 4'd2) begin fails++; $display("FAIL postreset_count got=%0d exp=2", count); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_reload_tc0();
        test_stop_at_tc();
        test_start_stop_and_ignore();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
